// File: rtl/alu_op_pkg.sv
// Shared ALU op encoding: opcode/funct constants and the decoded op struct.
// Used by both the issue stage and the EX-stage ALU.
package alu_op_pkg;

  localparam int OP_DATA_W = 32;
  localparam int OP_REG_W  = 5;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_MUL = 6'b000010;

  typedef struct packed {
    logic [OP_DATA_W-1:0] a;
    logic [OP_DATA_W-1:0] b;
    logic [5:0]           func;
    logic [OP_REG_W-1:0]  rd;
    logic                 we;
  } alu_op_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode into an ALU op plus legal flag.
// ALU_ISSUE_MUL_EN makes R-type funct 000010 (MUL) legal.
module alu_issue_decode
  import alu_op_pkg::*;
(
  input  logic [31:0]          instr,
  input  logic [OP_DATA_W-1:0] rs_data,
  input  logic [OP_DATA_W-1:0] rt_data,
  output alu_op_t              op,
  output logic                 legal
);

  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [15:0] imm;
  logic        unused_fields;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign imm    = instr[15:0];
  // Register specifiers for the sources are consumed by the regfile read upstream.
  assign unused_fields = ^instr[25:21];

  always_comb begin
    op    = '0;
    legal = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        op.a    = rs_data;
        op.b    = rt_data;
        op.func = funct;
        op.rd   = instr[15:11];
        case (funct)
          FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: legal = 1'b1;
`ifdef ALU_ISSUE_MUL_EN
          FN_MUL: legal = 1'b1;
`endif
          default: legal = 1'b0;
        endcase
      end
      OP_ADDI: begin
        op.a    = rs_data;
        op.b    = {{(OP_DATA_W-16){imm[15]}}, imm};
        op.func = OP_ADDI;
        op.rd   = instr[20:16];
        legal   = 1'b1;
      end
      OP_ANDI, OP_ORI: begin
        op.a    = rs_data;
        op.b    = {{(OP_DATA_W-16){1'b0}}, imm};
        op.func = opcode;
        op.rd   = instr[20:16];
        legal   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    op.we = (op.rd != '0);
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decode, valid/ready pipeline register, flush, illegal counter.
// Optional macro ALU_ISSUE_MUL_EN enables MUL issue in the decoder.
module alu_issue_stage
  import alu_op_pkg::*;
#(
  parameter int DATA_W     = OP_DATA_W,  // must match the package op struct
  parameter int REG_ADDR_W = OP_REG_W,
  parameter int CNT_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           instr,
  input  logic [DATA_W-1:0]     rs_data,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_a,
  output logic [DATA_W-1:0]     out_b,
  output logic [5:0]            out_func,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_we,
  output logic                  illegal,
  output logic [CNT_W-1:0]      illegal_cnt
);

  alu_op_t dec_op;
  logic    dec_legal;

  alu_issue_decode u_dec (
    .instr   (instr),
    .rs_data (rs_data),
    .rt_data (rt_data),
    .op      (dec_op),
    .legal   (dec_legal)
  );

  logic             out_valid_q, out_valid_d;
  alu_op_t          op_q, op_d;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             accept, xfer;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;
  assign xfer     = out_valid_q && out_ready;

  always_comb begin
    out_valid_d = out_valid_q;
    op_d        = op_q;
    illegal_d   = 1'b0;
    cnt_d       = cnt_q;
    if (xfer) out_valid_d = 1'b0;
    // A flush discards whatever is accepted alongside it.
    if (accept && !flush) begin
      if (dec_legal) begin
        op_d        = dec_op;
        out_valid_d = 1'b1;
      end else begin
        illegal_d = 1'b1;
        if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
      end
    end
    if (flush) out_valid_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      op_q        <= '0;
      illegal_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      op_q        <= op_d;
      illegal_q   <= illegal_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign out_a       = op_q.a;
  assign out_b       = op_q.b;
  assign out_func    = op_q.func;
  assign out_rd      = op_q.rd;
  assign out_we      = op_q.we;
  assign illegal     = illegal_q;
  assign illegal_cnt = cnt_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage; honours ALU_ISSUE_MUL_EN when defined.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] instr, rs_data, rt_data;
  logic        flush;
  logic        out_valid, out_ready;
  logic [31:0] out_a, out_b;
  logic [5:0]  out_func;
  logic [4:0]  out_rd;
  logic        out_we, illegal;
  logic [7:0]  illegal_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int exp_cnt;

  alu_issue_stage u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs_data     (rs_data),
    .rt_data     (rt_data),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_func    (out_func),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .illegal     (illegal),
    .illegal_cnt (illegal_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] rs, input logic [31:0] rt);
    in_valid = v;
    instr    = i;
    rs_data  = rs;
    rt_data  = rt;
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #12;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_a", out_a, 32'd0);
    chk("rst_func", {26'b0, out_func}, 32'd0);
    chk("rst_cnt", {24'b0, illegal_cnt}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    #5 rst_n = 1'b1;
    tick();

    // ADD r3 = r1 + r2
    drive(1'b1, 32'h00221820, 32'd5, 32'd7);
    tick();
    chk("add_valid", {31'b0, out_valid}, 32'd1);
    chk("add_a", out_a, 32'd5);
    chk("add_b", out_b, 32'd7);
    chk("add_func", {26'b0, out_func}, 32'h20);
    chk("add_rd", {27'b0, out_rd}, 32'd3);
    chk("add_we", {31'b0, out_we}, 32'd1);
    chk("add_illegal", {31'b0, illegal}, 32'd0);

    drive(1'b1, 32'h2022FFFF, 32'd10, 32'd0);
    tick();
    chk("addi_a", out_a, 32'd10);
    chk("addi_b", out_b, 32'hFFFFFFFF);
    chk("addi_func", {26'b0, out_func}, 32'h08);
    chk("addi_rd", {27'b0, out_rd}, 32'd2);

    drive(1'b1, 32'h3422FFFF, 32'd10, 32'd0);
    tick();
    chk("ori_b", out_b, 32'h0000FFFF);
    chk("ori_func", {26'b0, out_func}, 32'h0D);

    // Backpressure: ADD r4 held while out_ready=0, then AND r5 replaces it
    drive(1'b1, 32'h00432020, 32'd11, 32'd22);
    tick();
    chk("bp_load_a", out_a, 32'd11);
    out_ready = 1'b0;
    drive(1'b1, 32'h00A62824, 32'd3, 32'd6);
    #1 chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", {31'b0, out_valid}, 32'd1);
      chk("bp_hold_a", out_a, 32'd11);
      chk("bp_hold_func", {26'b0, out_func}, 32'h20);
    end
    out_ready = 1'b1;
    #1 chk("bp_release_ready", {31'b0, in_ready}, 32'd1);
    tick();
    chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
    chk("bp_next_a", out_a, 32'd3);
    chk("bp_next_func", {26'b0, out_func}, 32'h24);
    chk("bp_next_rd", {27'b0, out_rd}, 32'd5);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("bp_drain_valid", {31'b0, out_valid}, 32'd0);

    // Illegal opcode after a legal op: register contents untouched
    drive(1'b1, 32'h00221820, 32'd99, 32'd1);
    tick();
    drive(1'b1, 32'h10220005, 32'd1234, 32'd0);
    tick();
    chk("ill_op_pulse", {31'b0, illegal}, 32'd1);
    chk("ill_op_cnt", {24'b0, illegal_cnt}, 32'd1);
    chk("ill_op_valid", {31'b0, out_valid}, 32'd0);
    chk("ill_op_a_kept", out_a, 32'd99);
    drive(1'b1, 32'h00221802, 32'd8, 32'd9);
    tick();
`ifdef ALU_ISSUE_MUL_EN
    chk("mul_valid", {31'b0, out_valid}, 32'd1);
    chk("mul_func", {26'b0, out_func}, 32'h02);
    chk("mul_a", out_a, 32'd8);
    chk("mul_illegal", {31'b0, illegal}, 32'd0);
    exp_cnt = 1;
`else
    chk("mul_drop_valid", {31'b0, out_valid}, 32'd0);
    chk("mul_drop_pulse", {31'b0, illegal}, 32'd1);
    exp_cnt = 2;
`endif
    chk("mul_cnt", {24'b0, illegal_cnt}, exp_cnt);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    tick();
    chk("ill_pulse_end", {31'b0, illegal}, 32'd0);

    // Flush with a same-cycle illegal accept
    drive(1'b1, 32'h00221820, 32'd1, 32'd2);
    tick();
    drive(1'b1, 32'h10220005, 32'd0, 32'd0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_no_pulse", {31'b0, illegal}, 32'd0);
    chk("flush_cnt", {24'b0, illegal_cnt}, exp_cnt);
    // Flush with a legal accept while idle
    drive(1'b1, 32'h00221820, 32'd1, 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush_legal_valid", {31'b0, out_valid}, 32'd0);

    // rd == 0 still issues, without write enable
    drive(1'b1, 32'h00220020, 32'd4, 32'd4);
    tick();
    chk("rd0_valid", {31'b0, out_valid}, 32'd1);
    chk("rd0_rd", {27'b0, out_rd}, 32'd0);
    chk("rd0_we", {31'b0, out_we}, 32'd0);

    // Counter saturation
    for (int i = 0; i < 300; i++) begin
      drive(1'b1, 32'hFC000000, 32'd0, 32'd0);
      tick();
    end
    chk("sat_cnt", {24'b0, illegal_cnt}, 32'd255);
    chk("sat_pulse", {31'b0, illegal}, 32'd1);

    // Asynchronous reset mid-cycle with a valid op held
    drive(1'b1, 32'h00221820, 32'd77, 32'd88);
    tick();
    chk("prerst_valid", {31'b0, out_valid}, 32'd1);
    drive(1'b0, 32'h0, 32'h0, 32'h0);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_valid", {31'b0, out_valid}, 32'd0);
    chk("arst_a", out_a, 32'd0);
    chk("arst_b", out_b, 32'd0);
    chk("arst_we", {31'b0, out_we}, 32'd0);
    chk("arst_cnt", {24'b0, illegal_cnt}, 32'd0);
    #2 rst_n = 1'b1;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Producer side of the ALU interface: decodes a 32-bit MIPS instruction plus its two register-file read values into the ALU operand pair and 6-bit func code.
- Registers the result into the ID/EX pipeline register, with valid/ready handshakes on both sides.
- Sits between the ID-stage register-file read and the EX-stage ALU.
- Flags and drops unsupported encodings, and keeps a saturating illegal-instruction count.

Parameters:
- DATA_W, 32, operand/data width.
- REG_ADDR_W, 5, register address width.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- in_valid  input  1  instr/rs_data/rt_data are valid.
- in_ready  output  1  stage can accept input this cycle.
- instr  input  32  instruction word.
- rs_data  input  DATA_W  register-file value for instr[25:21].
- rt_data  input  DATA_W  register-file value for instr[20:16].
- flush  input  1  synchronous pipeline flush.
- out_valid  output  1  ID/EX register holds a valid op.
- out_ready  input  1  EX stage accepts the op.
- out_a  output  DATA_W  ALU operand a.
- out_b  output  DATA_W  ALU operand b.
- out_func  output  6  ALU func code.
- out_rd  output  REG_ADDR_W  destination register.
- out_we  output  1  register write enable.
- illegal  output  1  one-cycle pulse when an unsupported instruction is consumed.
- illegal_cnt  output  CNT_W  saturating count of illegal instructions.

Behaviour:
- Reset (async, rst_n=0): out_valid=0, out_a=0, out_b=0, out_func=0, out_rd=0, out_we=0, illegal=0, illegal_cnt=0.
- Handshake:
  - in_ready = !out_valid || out_ready (combinational); in_ready is not gated by flush.
  - Accept when in_valid && in_ready.
  - Output transfer when out_valid && out_ready.
  - Once out_valid=1, out_* stay stable until transfer.
- Latency: 1 cycle from accept to out_valid. Full throughput (one op per cycle) while out_ready=1.
- Decode (opcode = instr[31:26]):
  - opcode 000000, R-type:
    - a=rs_data, b=rt_data, func=instr[5:0], rd=instr[15:11].
    - Legal funct: 100000 ADD, 100010 SUB, 100100 AND, 100101 OR, 101010 SLT.
    - 000010 MUL is legal only per the optional feature.
  - 001000 ADDI: a=rs_data, b=sign-extended instr[15:0], func=001000, rd=instr[20:16].
  - 001100 ANDI / 001101 ORI: a=rs_data, b=zero-extended instr[15:0], func=opcode, rd=instr[20:16].
  - out_we = 1 unless rd==0 (in which case out_we=0; the op is still issued).
- Illegal encoding (any other opcode, or unsupported R-type funct):
  - The instruction is accepted (consumed) but not loaded; out_valid is unaffected by it.
  - illegal pulses high for 1 cycle, on the cycle after accept.
  - illegal_cnt increments and saturates at 2^CNT_W-1; no wrap.
- Flush:
  - The next cycle has out_valid=0, regardless of out_ready.
  - An input accepted in the flush cycle is discarded: no load, no illegal pulse, no count.
  - illegal_cnt is not cleared by flush.
- Simultaneous transfer and accept: the register is overwritten with the new op and out_valid stays 1.
- Reset mid-operation: the in-flight op is lost and all outputs return to reset values immediately.

Optional Feature:
- Macro: ALU_ISSUE_MUL_EN.
- Defined: R-type funct 000010 is legal and issued as MUL (a=rs_data, b=rt_data, func=000010).
- Undefined: funct 000010 is illegal (dropped, illegal pulse, counter increment).

Decomposition:
- Shared package alu_op_pkg:
  - opcode constants OP_RTYPE, OP_ADDI, OP_ANDI, OP_ORI.
  - funct constants FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT, FN_MUL.
  - Typedef for the decoded op struct {a, b, func, rd, we}.
  - The ALU and this block both use the package.
- One natural sub-module: alu_issue_decode.
  - Purely combinational: instr/rs_data/rt_data -> decoded op struct plus legal flag.
  - Gated by ALU_ISSUE_MUL_EN.
  - The top level holds the handshake, pipeline register, flush and counter.

Test Plan:
1. Reset, then accept ADD 0x00221820 (rs=1, rt=2, rd=3) with rs_data=5, rt_data=7, out_ready=1 -> next cycle out_valid=1, a=5, b=7, func=100000, rd=3, we=1.
2. ADDI 0x2022FFFF with rs_data=10 -> b=0xFFFFFFFF, func=001000, rd=2. ORI 0x3422FFFF -> b=0x0000FFFF, func=001101.
3. out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, out_* stable. Raise out_ready -> back-to-back transfer plus new accept in the same cycle, no lost or duplicated op.
4. opcode 000100, then R-type funct 000010 without macro -> op dropped, illegal pulses once per instruction, illegal_cnt=2. With ALU_ISSUE_MUL_EN, funct 000010 -> issued with func=000010. Drive 300 illegal ops with CNT_W=8 -> illegal_cnt=255.
5. flush with out_valid=1 and a same-cycle accept -> next cycle out_valid=0, no illegal pulse. R-type with rd=0 -> issued with we=0.
6. Assert rst_n=0 asynchronously while out_valid=1 mid-cycle -> outputs reset immediately, illegal_cnt=0.
